// File: rtl/jpeg_image_buffer_pkg.sv
// jpeg_image_buffer_pkg: shared FSM state type, EOI marker constant and the
// byte-address split helper used by the JPEG image buffer.
package jpeg_image_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2,
      STREAM  = 2'd3
   } state_t;

   // JPEG end-of-image marker as it appears in the byte stream (FF then D9).
   localparam logic [15:0] EOI_MARKER = 16'hFFD9;

   typedef struct packed {
      logic [29:0] word_idx;
      logic [1:0]  lane;
   } byte_addr_t;

   // Split a byte address into 32-bit word index and byte lane.
   function automatic byte_addr_t split_addr(input logic [31:0] addr);
      byte_addr_t s;
      s.word_idx = addr[31:2];
      s.lane     = addr[1:0];
      return s;
   endfunction

endpackage

// File: rtl/jpeg_image_buffer_if.sv
// jpeg_image_buffer_if: encoder write bus, completion status and byte-stream
// readout of the JPEG image buffer. The eoi_error_out signal only exists
// when JPEG_EOI_CHECK_EN is defined.
interface jpeg_image_buffer_if #(
   parameter int AW = 16
);
   logic          capture_start_in;
   logic [31:0]   data_in;
   logic [AW-1:0] address_in;
   logic          data_valid_in;
   logic          image_valid_in;
   logic          image_ready_out;
   logic [AW-1:0] image_size_out;
   logic          overflow_out;
   logic          read_start_in;
   logic [AW-1:0] read_offset_in;
   logic [7:0]    byte_out;
   logic          byte_valid_out;
   logic          byte_ready_in;
   logic          byte_last_out;
`ifdef JPEG_EOI_CHECK_EN
   logic          eoi_error_out;

   modport master (
      output capture_start_in, data_in, address_in, data_valid_in, image_valid_in,
             read_start_in, read_offset_in, byte_ready_in,
      input  image_ready_out, image_size_out, overflow_out, byte_out,
             byte_valid_out, byte_last_out, eoi_error_out
   );

   modport slave (
      input  capture_start_in, data_in, address_in, data_valid_in, image_valid_in,
             read_start_in, read_offset_in, byte_ready_in,
      output image_ready_out, image_size_out, overflow_out, byte_out,
             byte_valid_out, byte_last_out, eoi_error_out
   );
`else
   modport master (
      output capture_start_in, data_in, address_in, data_valid_in, image_valid_in,
             read_start_in, read_offset_in, byte_ready_in,
      input  image_ready_out, image_size_out, overflow_out, byte_out,
             byte_valid_out, byte_last_out
   );

   modport slave (
      input  capture_start_in, data_in, address_in, data_valid_in, image_valid_in,
             read_start_in, read_offset_in, byte_ready_in,
      output image_ready_out, image_size_out, overflow_out, byte_out,
             byte_valid_out, byte_last_out
   );
`endif
endinterface

// File: rtl/jpeg_image_buffer_ram.sv
// jpeg_image_buffer_ram: simple dual-port 32-bit word RAM, one write port and
// one registered read port. Contents are not reset.
module jpeg_image_buffer_ram #(
   parameter int DEPTH = 4096,
   parameter int WW    = 12
) (
   input  logic          clock_in,
   input  logic          write_en,
   input  logic [WW-1:0] write_addr,
   input  logic [31:0]   write_data,
   input  logic [WW-1:0] read_addr,
   output logic [31:0]   read_data
);
   logic [31:0] mem [DEPTH];

   // Word write, committed at the clock edge.
   always_ff @(posedge clock_in) begin
      if (write_en) mem[write_addr] <= write_data;
   end

   // Registered read: data for read_addr appears one cycle later.
   always_ff @(posedge clock_in) begin
      read_data <= mem[read_addr];
   end
endmodule

// File: rtl/jpeg_image_buffer.sv
// jpeg_image_buffer: captures encoder words into on-chip RAM, latches the
// image size on completion and streams the image back out byte by byte.
// Optional feature macro: JPEG_EOI_CHECK_EN (end-of-image marker check).
module jpeg_image_buffer
   import jpeg_image_buffer_pkg::*;
#(
   parameter int BUF_BYTES = 16384,
   parameter int AW        = 16
) (
   input logic                clock_in,
   input logic                reset_in,
   jpeg_image_buffer_if.slave bus
);
   localparam int          DEPTH    = BUF_BYTES / 4;
   localparam int          WW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] BUF_SIZE = (AW+1)'(BUF_BYTES);

   state_t        state_reg, state_next;
   logic          image_ready_reg, overflow_reg;
   logic [AW-1:0] image_size_reg, ptr_reg, issue_ptr;
   logic          fetch_valid_reg, fetch_last_reg;
   logic [1:0]    fetch_lane_reg, skid_count_reg;
   logic [7:0]    skid_data_reg [2];
   logic          skid_last_reg [2];

   byte_addr_t    wr_split, rd_split;
   logic          wr_in_range, write_en, stream_ok, issue_en;
   logic          pop, push, credit_ok, stream_end, unused_bits;
   logic [AW:0]   size_clamped;
   logic [31:0]   read_data;
   logic [7:0]    fetch_byte;

   assign wr_split     = split_addr(32'(bus.address_in));
   assign rd_split     = split_addr(32'(issue_ptr));
   assign wr_in_range  = (wr_split.word_idx < 30'(DEPTH));
   assign write_en     = (state_reg == CAPTURE) && bus.data_valid_in && wr_in_range;
   assign size_clamped = ({1'b0, bus.address_in} > BUF_SIZE) ? BUF_SIZE : {1'b0, bus.address_in};
   assign stream_ok    = bus.read_start_in && (bus.read_offset_in < image_size_reg);
   assign pop          = (skid_count_reg != 2'd0) && bus.byte_ready_in;
   assign push         = fetch_valid_reg;
   assign stream_end   = pop && skid_last_reg[0];
   assign fetch_byte   = read_data[{fetch_lane_reg, 3'b000} +: 8];
   // Bytes already in the skid plus the one leaving the RAM must leave room
   // for the fetch being issued now; a pop in the same cycle frees a slot.
   assign credit_ok    = ({1'b0, skid_count_reg} + {2'b00, fetch_valid_reg}) < (3'd2 + {2'b00, pop});
   assign unused_bits  = &{1'b0, wr_split.lane, rd_split.word_idx[29:WW], size_clamped[AW]};

   jpeg_image_buffer_ram #(.DEPTH(DEPTH), .WW(WW)) u_ram (
      .clock_in   (clock_in),
      .write_en   (write_en),
      .write_addr (wr_split.word_idx[WW-1:0]),
      .write_data (bus.data_in),
      .read_addr  (rd_split.word_idx[WW-1:0]),
      .read_data  (read_data)
   );

   // Next state and RAM fetch issue. The first fetch goes straight from
   // read_offset_in so the first byte is presented two cycles after the request.
   always_comb begin
      state_next = state_reg;
      issue_en   = 1'b0;
      issue_ptr  = ptr_reg;
      case (state_reg)
         IDLE:    state_next = state_reg;
         CAPTURE: if (bus.image_valid_in) state_next = DONE;
         DONE: begin
            if (stream_ok) begin
               state_next = STREAM;
               issue_en   = 1'b1;
               issue_ptr  = bus.read_offset_in;
            end
         end
         STREAM: begin
            if (credit_ok && (ptr_reg < image_size_reg)) issue_en = 1'b1;
            if (stream_end) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
      if (bus.capture_start_in) begin
         state_next = CAPTURE;
         issue_en   = 1'b0;
      end
   end

   // State register, completion flags, size latch and sticky overflow.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_reg       <= IDLE;
         image_ready_reg <= 1'b0;
         image_size_reg  <= '0;
         overflow_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (bus.capture_start_in) begin
            image_ready_reg <= 1'b0;
            image_size_reg  <= '0;
            overflow_reg    <= 1'b0;
         end else if (state_reg == CAPTURE) begin
            if (bus.data_valid_in && !wr_in_range) overflow_reg <= 1'b1;
            if (bus.image_valid_in) begin
               image_size_reg  <= size_clamped[AW-1:0];
               image_ready_reg <= 1'b1;
            end
         end
      end
   end

   // Byte pointer and the lane/last tags travelling alongside the RAM read.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         ptr_reg         <= '0;
         fetch_valid_reg <= 1'b0;
         fetch_lane_reg  <= 2'd0;
         fetch_last_reg  <= 1'b0;
      end else begin
         fetch_valid_reg <= issue_en;
         if (issue_en) begin
            ptr_reg        <= issue_ptr + AW'(1);
            fetch_lane_reg <= rd_split.lane;
            fetch_last_reg <= (issue_ptr == image_size_reg - AW'(1));
         end
      end
   end

   // Two-entry skid: entry 0 drives the output and only moves on a pop.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         skid_count_reg   <= 2'd0;
         skid_data_reg[0] <= 8'd0;
         skid_data_reg[1] <= 8'd0;
         skid_last_reg[0] <= 1'b0;
         skid_last_reg[1] <= 1'b0;
      end else if (bus.capture_start_in) begin
         skid_count_reg <= 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (skid_count_reg == 2'd1) begin
                  skid_data_reg[0] <= fetch_byte;
                  skid_last_reg[0] <= fetch_last_reg;
               end else begin
                  skid_data_reg[0] <= skid_data_reg[1];
                  skid_last_reg[0] <= skid_last_reg[1];
                  skid_data_reg[1] <= fetch_byte;
                  skid_last_reg[1] <= fetch_last_reg;
               end
            end
            2'b01: begin
               skid_data_reg[0] <= skid_data_reg[1];
               skid_last_reg[0] <= skid_last_reg[1];
               skid_count_reg   <= skid_count_reg - 2'd1;
            end
            2'b10: begin
               if (skid_count_reg == 2'd0) begin
                  skid_data_reg[0] <= fetch_byte;
                  skid_last_reg[0] <= fetch_last_reg;
               end else begin
                  skid_data_reg[1] <= fetch_byte;
                  skid_last_reg[1] <= fetch_last_reg;
               end
               skid_count_reg <= skid_count_reg + 2'd1;
            end
            default: skid_count_reg <= skid_count_reg;
         endcase
      end
   end

   assign bus.image_ready_out = image_ready_reg;
   assign bus.image_size_out  = image_size_reg;
   assign bus.overflow_out    = overflow_reg;
   assign bus.byte_out        = skid_data_reg[0];
   assign bus.byte_valid_out  = (skid_count_reg != 2'd0);
   assign bus.byte_last_out   = (skid_count_reg != 2'd0) && skid_last_reg[0];

`ifdef JPEG_EOI_CHECK_EN
   logic [AW-1:0] tail_addr_reg, tail_addr_eff;
   logic [15:0]   tail_hi_reg, tail_hi_eff;
   logic          tail_seen_reg, tail_seen_eff, eoi_error_reg, eoi_ok;

   // Most recent in-range word, including one written in the completion cycle.
   always_comb begin
      tail_addr_eff = tail_addr_reg;
      tail_hi_eff   = tail_hi_reg;
      tail_seen_eff = tail_seen_reg;
      if (write_en) begin
         tail_addr_eff = bus.address_in;
         tail_hi_eff   = bus.data_in[31:16];
         tail_seen_eff = 1'b1;
      end
   end

   // Size is word aligned, so the last two bytes are the top lanes of the word at size-4.
   assign eoi_ok = tail_seen_eff && (size_clamped >= (AW+1)'(2)) &&
                   (({1'b0, tail_addr_eff} + (AW+1)'(4)) == size_clamped) &&
                   (tail_hi_eff == {EOI_MARKER[7:0], EOI_MARKER[15:8]});

   // Track the tail word during capture and grade the marker at completion.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         tail_addr_reg <= '0;
         tail_hi_reg   <= 16'd0;
         tail_seen_reg <= 1'b0;
         eoi_error_reg <= 1'b0;
      end else if (bus.capture_start_in) begin
         tail_addr_reg <= '0;
         tail_hi_reg   <= 16'd0;
         tail_seen_reg <= 1'b0;
         eoi_error_reg <= 1'b0;
      end else if (state_reg == CAPTURE) begin
         tail_addr_reg <= tail_addr_eff;
         tail_hi_reg   <= tail_hi_eff;
         tail_seen_reg <= tail_seen_eff;
         if (bus.image_valid_in) eoi_error_reg <= !eoi_ok;
      end
   end

   assign bus.eoi_error_out = eoi_error_reg;
`endif
endmodule
